// File: rtl/uart_rx_async.sv
// Asynchronous UART receiver: 16x oversampled start-bit validation, 7/8 data bits LSB-first,
// optional parity, stop-bit check, delivery to a holding register or an external FIFO.
module uart_rx_async #(
  parameter int unsigned RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_parity,
  input  logic       clear_framing,
  input  logic       fifo_full,
  output logic [7:0] rx_dout,
  output logic       rx_ready,
  output logic       fifo_write,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } state_e;

  state_e     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       par_bad_q, par_bad_d;
  logic       frame_bad_q, frame_bad_d;
  logic       deliver_q, deliver_d;
  logic [7:0] rx_dout_q, rx_dout_d;
  logic       rx_ready_q, rx_ready_d;
  logic       fifo_write_q, fifo_write_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;

  logic [2:0] last_bit;
  logic [7:0] rx_byte;
  logic       bit_centre;

  assign last_bit   = bit8 ? 3'd7 : 3'd6;
  assign bit_centre = baud_clock && (cnt_q == 4'hf);
  // 7-bit frames leave the first data bit one position above the LSB
  assign rx_byte    = bit8 ? shift_q : {1'b0, shift_q[7:1]};

  // Frame sequencing: every transition is qualified by baud_clock
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    par_bad_d   = par_bad_q;
    frame_bad_d = frame_bad_q;
    deliver_d   = 1'b0;
    if (baud_clock) begin
      case (state_q)
        RX_IDLE: begin
          if (rx_s_q) begin
            cnt_d = '0;
          end else if (cnt_q == 4'd7) begin
            cnt_d     = '0;
            bitcnt_d  = '0;
            shift_d   = '0;
            par_d     = 1'b0;
            par_bad_d = 1'b0;
            state_d   = RX_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        RX_DATA: begin
          cnt_d = cnt_q + 4'd1;
          if (bit_centre) begin
            shift_d  = {rx_s_q, shift_q[7:1]};
            par_d    = par_q ^ rx_s_q;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == last_bit) begin
              state_d = parity_en ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          cnt_d = cnt_q + 4'd1;
          if (bit_centre) begin
            par_bad_d = par_q ^ rx_s_q ^ odd_n_even;
            state_d   = RX_STOP;
          end
        end
        RX_STOP: begin
          cnt_d = cnt_q + 4'd1;
          if (bit_centre) begin
            frame_bad_d = ~rx_s_q;
            deliver_d   = 1'b1;
            state_d     = rx_s_q ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = RX_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  // Delivery and sticky flags: a set in the delivery cycle overrides a clear
  always_comb begin
    rx_dout_d     = rx_dout_q;
    rx_ready_d    = rx_ready_q;
    fifo_write_d  = 1'b0;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    if (clear_parity) parity_err_d = 1'b0;
    if (clear_framing) framing_err_d = 1'b0;
    if (read_rx_byte) overflow_d = 1'b0;
    if (deliver_q && par_bad_q) parity_err_d = 1'b1;
    if (deliver_q && frame_bad_q) framing_err_d = 1'b1;
    if (RX_FIFO == 0) begin
      if (deliver_q) begin
        if (!rx_ready_q || read_rx_byte) begin
          rx_dout_d  = rx_byte;
          rx_ready_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (read_rx_byte) begin
        rx_ready_d = 1'b0;
      end
    end else begin
      rx_ready_d = 1'b0;
      if (deliver_q) begin
        if (!fifo_full) begin
          fifo_write_d = 1'b1;
          rx_dout_d    = rx_byte;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      par_bad_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      deliver_q     <= 1'b0;
      rx_dout_q     <= '0;
      rx_ready_q    <= 1'b0;
      fifo_write_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      par_bad_q     <= par_bad_d;
      frame_bad_q   <= frame_bad_d;
      deliver_q     <= deliver_d;
      rx_dout_q     <= rx_dout_d;
      rx_ready_q    <= rx_ready_d;
      fifo_write_q  <= fifo_write_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_dout     = rx_dout_q;
  assign rx_ready    = rx_ready_q;
  assign fifo_write  = fifo_write_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async: holding-register instance (dut0) and FIFO instance (dut1)
// share the serial line and controls; baud tick every 4 clk, so one bit = 64 clk.
module tb_uart_rx_async;

  logic clk = 1'b0;
  logic reset, baud_clock, rx, bit8, parity_en, odd_n_even;
  logic read_rx_byte, clear_parity, clear_framing, fifo_full;
  logic [7:0] rx_dout0, rx_dout1;
  logic rx_ready0, rx_ready1, fifo_write0, fifo_write1;
  logic parity_err0, parity_err1, framing_err0, framing_err1, overflow0, overflow1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int read_off = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int fw_cnt = 0;
  int fw0_cnt = 0;
  int lat = 0;
  logic [7:0] fw_data = 8'h00;
  logic rdy_prev = 1'b0;

  uart_rx_async #(.RX_FIFO(0)) dut0 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_parity(clear_parity), .clear_framing(clear_framing), .fifo_full(fifo_full),
    .rx_dout(rx_dout0), .rx_ready(rx_ready0), .fifo_write(fifo_write0),
    .parity_err(parity_err0), .framing_err(framing_err0), .overflow(overflow0)
  );

  uart_rx_async #(.RX_FIFO(1)) dut1 (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx), .bit8(bit8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read_rx_byte(read_rx_byte),
    .clear_parity(clear_parity), .clear_framing(clear_framing), .fifo_full(fifo_full),
    .rx_dout(rx_dout1), .rx_ready(rx_ready1), .fifo_write(fifo_write1),
    .parity_err(parity_err1), .framing_err(framing_err1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    baud_clock = 1'b0;
    forever begin
      @(negedge clk);
      baud_clock = (cyc % 4 == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_ready0 && !rdy_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    rdy_prev = rx_ready0;
    if (fifo_write1) begin
      fw_cnt++;
      fw_data = rx_dout1;
    end
    if (fifo_write0) fw0_cnt++;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (64) begin
      @(negedge clk);
      if (read_off != 0) read_rx_byte = ((cyc - start_cyc) == (read_off - 1));
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned nbits,
                            input logic has_par, input logic pbit, input logic stop);
    do @(negedge clk); while (cyc % 4 != 0);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int unsigned i = 0; i < nbits; i++) drive_bit(d[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int unsigned n);
    rx = 1'b1;
    repeat (n * 64) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk); read_rx_byte = 1'b1;
    @(negedge clk); read_rx_byte = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_dout0 !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h exp 00", rx_dout0); end
    n_cmp++; if ({rx_ready0, parity_err0, framing_err0, overflow0, fifo_write0} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags0 got %b exp 00000", {rx_ready0, parity_err0, framing_err0, overflow0, fifo_write0}); end
    n_cmp++; if ({rx_ready1, fifo_write1, overflow1} !== 3'b0) begin
      n_bad++; $display("FAIL reset_flags1 got %b exp 000", {rx_ready1, fifo_write1, overflow1}); end
  endtask

  task automatic test_8n1();
    int c;
    c = fw_cnt;
    rise_cyc = 0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    lat = rise_cyc - start_cyc;
    n_cmp++; if (rx_ready0 !== 1'b1) begin n_bad++; $display("FAIL 8n1_ready got %b exp 1", rx_ready0); end
    n_cmp++; if (rx_dout0 !== 8'hA5) begin n_bad++; $display("FAIL 8n1_dout got %h exp a5", rx_dout0); end
    n_cmp++; if ({parity_err0, framing_err0, overflow0} !== 3'b0) begin
      n_bad++; $display("FAIL 8n1_errs got %b exp 000", {parity_err0, framing_err0, overflow0}); end
    n_cmp++; if (lat < 600 || lat > 630) begin n_bad++; $display("FAIL 8n1_latency got %0d clk exp 600..630", lat); end
    n_cmp++; if (fw_cnt !== c + 1 || fw_data !== 8'hA5) begin
      n_bad++; $display("FAIL 8n1_fifo got %0d writes data %h exp %0d data a5", fw_cnt - c, fw_data, 1); end
    pulse_read();
    n_cmp++; if (rx_ready0 !== 1'b0) begin n_bad++; $display("FAIL 8n1_read got %b exp 0", rx_ready0); end
  endtask

  task automatic test_parity();
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
    // 0x53 as 7 bits = 1010011: four ones, so the even parity bit is 0
    send_frame(8'h53, 7, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    n_cmp++; if (rx_dout0 !== 8'h53 || rx_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL par_good got %h/%b exp 53/1", rx_dout0, rx_ready0); end
    n_cmp++; if (parity_err0 !== 1'b0) begin n_bad++; $display("FAIL par_good_err got %b exp 0", parity_err0); end
    pulse_read();
    send_frame(8'h53, 7, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    n_cmp++; if (parity_err0 !== 1'b1) begin n_bad++; $display("FAIL par_bad_err got %b exp 1", parity_err0); end
    n_cmp++; if (rx_dout0 !== 8'h53) begin n_bad++; $display("FAIL par_bad_dout got %h exp 53", rx_dout0); end
    pulse_read();
    n_cmp++; if (parity_err0 !== 1'b1) begin n_bad++; $display("FAIL par_sticky got %b exp 1", parity_err0); end
    @(negedge clk); clear_parity = 1'b1;
    @(negedge clk); clear_parity = 1'b0;
    @(negedge clk);
    n_cmp++; if (parity_err0 !== 1'b0) begin n_bad++; $display("FAIL par_clear got %b exp 0", parity_err0); end
    bit8 = 1'b1; parity_en = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_glitch_framing();
    int r, c;
    r = rise_cnt; c = fw_cnt;
    do @(negedge clk); while (cyc % 4 != 0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(3);
    n_cmp++; if (rise_cnt !== r || fw_cnt !== c || rx_ready0 !== 1'b0) begin
      n_bad++; $display("FAIL glitch got %0d/%0d deliveries exp 0/0", rise_cnt - r, fw_cnt - c); end
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * 640) @(negedge clk);
    idle_bits(2);
    n_cmp++; if (rise_cnt !== r + 1 || fw_cnt !== c + 1) begin
      n_bad++; $display("FAIL break_count got %0d/%0d deliveries exp 1/1", rise_cnt - r, fw_cnt - c); end
    n_cmp++; if (framing_err0 !== 1'b1) begin n_bad++; $display("FAIL framing_err got %b exp 1", framing_err0); end
    n_cmp++; if (rx_dout0 !== 8'h3C) begin n_bad++; $display("FAIL framing_dout got %h exp 3c", rx_dout0); end
    pulse_read();
    @(negedge clk); clear_framing = 1'b1;
    @(negedge clk); clear_framing = 1'b0;
    @(negedge clk);
    n_cmp++; if (framing_err0 !== 1'b0) begin n_bad++; $display("FAIL framing_clear got %b exp 0", framing_err0); end
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    n_cmp++; if (rx_dout0 !== 8'h11 || rx_ready0 !== 1'b1 || framing_err0 !== 1'b0) begin
      n_bad++; $display("FAIL after_break got %h/%b/%b exp 11/1/0", rx_dout0, rx_ready0, framing_err0); end
    pulse_read();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    send_frame(8'h02, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    n_cmp++; if (rx_dout0 !== 8'h01 || rx_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL overrun_dout got %h/%b exp 01/1", rx_dout0, rx_ready0); end
    n_cmp++; if (overflow0 !== 1'b1) begin n_bad++; $display("FAIL overrun_flag got %b exp 1", overflow0); end
    // Read lands exactly on the cycle before the load edge measured for 8N1
    read_off = lat;
    send_frame(8'h03, 8, 1'b0, 1'b0, 1'b1);
    read_off = 0;
    read_rx_byte = 1'b0;
    idle_bits(1);
    n_cmp++; if (rx_dout0 !== 8'h03 || rx_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL read_same_cycle got %h/%b exp 03/1", rx_dout0, rx_ready0); end
    n_cmp++; if (overflow0 !== 1'b0) begin n_bad++; $display("FAIL overrun_clear got %b exp 0", overflow0); end
    pulse_read();
  endtask

  task automatic test_fifo();
    int c;
    c = fw_cnt;
    fifo_full = 1'b0;
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    n_cmp++; if (fw_cnt !== c + 1 || fw_data !== 8'h7E) begin
      n_bad++; $display("FAIL fifo_write got %0d cycles data %h exp 1 data 7e", fw_cnt - c, fw_data); end
    n_cmp++; if (overflow1 !== 1'b0 || rx_ready1 !== 1'b0) begin
      n_bad++; $display("FAIL fifo_flags got %b%b exp 00", overflow1, rx_ready1); end
    fifo_full = 1'b1;
    send_frame(8'h7F, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    fifo_full = 1'b0;
    n_cmp++; if (fw_cnt !== c + 1) begin n_bad++; $display("FAIL fifo_full_write got %0d exp 1", fw_cnt - c); end
    n_cmp++; if (overflow1 !== 1'b1) begin n_bad++; $display("FAIL fifo_overflow got %b exp 1", overflow1); end
    n_cmp++; if (fw0_cnt !== 0) begin n_bad++; $display("FAIL nofifo_strobe got %0d exp 0", fw0_cnt); end
  endtask

  task automatic test_reset_midframe();
    int r, c;
    do @(negedge clk); while (cyc % 4 != 0);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (4 * 64 + 32) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    r = rise_cnt; c = fw_cnt;
    n_cmp++; if ({rx_dout0, rx_ready0, parity_err0, framing_err0, overflow0} !== 12'h000) begin
      n_bad++; $display("FAIL midreset0 got %h exp 000", {rx_dout0, rx_ready0, parity_err0, framing_err0, overflow0}); end
    n_cmp++; if ({overflow1, fifo_write1} !== 2'b00) begin
      n_bad++; $display("FAIL midreset1 got %b exp 00", {overflow1, fifo_write1}); end
    idle_bits(7);
    n_cmp++; if (rise_cnt !== r || fw_cnt !== c) begin
      n_bad++; $display("FAIL midreset_nodeliver got %0d/%0d exp 0/0", rise_cnt - r, fw_cnt - c); end
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    n_cmp++; if (rise_cnt !== r + 1 || rx_ready0 !== 1'b1 || rx_dout0 !== 8'h00) begin
      n_bad++; $display("FAIL post_reset0 got %0d/%b/%h exp 1/1/00", rise_cnt - r, rx_ready0, rx_dout0); end
    n_cmp++; if (fw_cnt !== c + 1 || fw_data !== 8'h00) begin
      n_bad++; $display("FAIL post_reset1 got %0d data %h exp 1 data 00", fw_cnt - c, fw_data); end
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    read_rx_byte = 1'b0; clear_parity = 1'b0; clear_framing = 1'b0; fifo_full = 1'b0;
    test_reset();
    test_8n1();
    test_parity();
    test_glitch_framing();
    test_back_to_back();
    test_fifo();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
Asynchronous UART receiver. It is the receive-side counterpart of the core's transmit engine. It oversamples the serial line with the core's 16x baud tick, validates the start bit, and shifts in 7 or 8 data bits LSB-first. It then checks optional parity and the stop bit, and delivers each byte either to a holding register with a ready flag or, in FIFO mode, as a one-cycle write strobe to the receive FIFO.

Parameters:
RX_FIFO, 0, 0 = single holding register with rx_ready handshake; 1 = write each byte into an external receive FIFO.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
baud_clock  input  1  one-clk-wide pulse at 16x the bit rate
rx  input  1  serial input, asynchronous to clk, idle high
bit8  input  1  1 = 8 data bits, 0 = 7 data bits
parity_en  input  1  1 = a parity bit follows the data bits
odd_n_even  input  1  1 = odd parity, 0 = even parity
read_rx_byte  input  1  one-cycle pulse; host has consumed rx_dout (RX_FIFO=0 only)
clear_parity  input  1  one-cycle pulse; clears parity_err
clear_framing  input  1  one-cycle pulse; clears framing_err
fifo_full  input  1  receive FIFO full (RX_FIFO=1 only)
rx_dout  output  8  received byte
rx_ready  output  1  rx_dout holds an unread byte (RX_FIFO=0; tied 0 when RX_FIFO=1)
fifo_write  output  1  one-cycle write strobe, active high (RX_FIFO=1; tied 0 when RX_FIFO=0)
parity_err  output  1  sticky parity error
framing_err  output  1  sticky framing error
overflow  output  1  sticky overrun: a byte arrived with no space for it

Behaviour:
- Reset is synchronous, active-high, and wins over all other inputs. On reset: rx_dout=0, rx_ready=0, fifo_write=0, all error flags 0, synchroniser flops=1, state=rx_idle, counters=0. Reset mid-frame aborts the frame and delivers nothing.
- Input synchroniser: rx passes through 2 clk flops before use (rx_s). All decisions below use rx_s.
- Sample counter: 4-bit, advances only on baud_clock. All state transitions occur only on baud_clock cycles.
- rx_idle: while rx_s=0, count baud_clock ticks. Reaching count 7 (8th low sample, which is mid start bit) clears the counter and moves to rx_data. If rx_s returns to 1 before then, clear the counter and stay in rx_idle (glitch rejection).
- rx_data: sample rx_s when the counter wraps 15 to 0 (bit centre). Shift the sample into the MSB side of the shift register (LSB-first on the line) and XOR it into the running parity. After 8 samples (bit8=1) or 7 samples (bit8=0), go to rx_parity if parity_en=1, otherwise to rx_stop. In 7-bit mode the delivered rx_dout[7]=0.
- rx_parity: sample at bit centre. Error when (data XOR parity bit XOR odd_n_even) differs from the expected value: even parity requires an even total count of ones, odd parity an odd count. Go to rx_stop.
- rx_stop: sample at bit centre.
  - Sample = 1: deliver the byte and go to rx_idle.
  - Sample = 0: set framing_err, still deliver the byte, and go to rx_break.
- rx_break: wait until rx_s=1, then go to rx_idle. A held-low line therefore yields exactly one byte.
- Parity and framing errors are flagged in the same clk cycle as delivery.
- Delivery with RX_FIFO=0, on the clk cycle after the stop-bit sample:
  - rx_ready=0, or read_rx_byte=1 in the same cycle: load rx_dout and set rx_ready=1.
  - Otherwise: set overflow, discard the new byte, and leave rx_dout unchanged.
- read_rx_byte with no delivery clears rx_ready.
- Delivery with RX_FIFO=1, on the clk cycle after the stop-bit sample:
  - fifo_full=0: fifo_write=1 for exactly one cycle, with rx_dout valid in that cycle.
  - fifo_full=1: no write; set overflow.
- Sticky flags:
  - parity_err is cleared only by clear_parity, framing_err only by clear_framing, and overflow only by read_rx_byte.
  - A clear and a new set in the same cycle: the set wins.
- Configuration inputs (bit8, parity_en, odd_n_even) may change only while in rx_idle. Changes mid-frame are undefined.
- Latency from the start-bit falling edge to delivery: about 2 clk + (0.5 + data bits + parity + 1) bit times, e.g. 9.5 bit times for 8N1.

Test Plan:
1. RX_FIFO=0, 8N1: send 0xA5 → rx_dout=0xA5 and rx_ready=1 at about 9.5 bit times; all error flags 0; read_rx_byte → rx_ready=0.
2. bit8=0, parity_en=1, odd_n_even=0: send 0x53 with correct even parity, then the same frame with the parity bit inverted → second frame gives parity_err=1 and rx_dout=0x53; clear_parity → 0.
3. Glitch rejection: rx low for 5 baud ticks then high → state stays rx_idle, no delivery. Framing: 0x3C with stop bit=0 → framing_err=1, byte delivered; line held low 3 frame times then released → exactly one delivery, then normal reception of the next byte 0x11.
4. Overrun: send 0x01 and 0x02 without reading → rx_dout=0x01, overflow=1. Then send 0x03 with read_rx_byte in the delivery cycle → rx_dout=0x03, rx_ready=1, overflow cleared.
5. RX_FIFO=1: send 0x7E with fifo_full=0 → a single fifo_write pulse with rx_dout=0x7E. Send 0x7F with fifo_full=1 → no strobe, overflow=1.
6. Assert reset in the middle of data bit 4 of 0xFF → all outputs reset, no delivery; the next frame 0x00 is received correctly.
